shift_mix_columns: RTL and testbench

Sequential AES round stage directly downstream of SubBytes. It consumes the 128-bit SubBytes output (`Out_SBT`), applies ShiftRows, then MixColumns one column per clock. The result feeds AddRoundKey. A per-operation `Last_SMC` flag bypasses MixColumns for the final AES round. The enable/ready handshake matches the other round stages.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/mix_single_column.sv | 31 +++
 rtl/shift_mix_columns.sv | 97 +++++++++
 tb/tb_shift_mix_columns.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared AES round-stage definitions: state width, byte
//                addressing, GF(2^8) xtime and round-stage FSM encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int AES_STATE_W = 128;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_mix    = 2'd1;
    localparam logic [1:0] c_st_commit = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    // MSB position of byte s(r,c) in the row-major 128-bit state
    function automatic int byte_idx(input int r, input int c);
        return AES_STATE_W - 1 - 8 * (4 * r + c);
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_single_column.sv
`default_nettype none
// ============================================================================
//  Module      : mix_single_column
//  Description : Combinational AES MixColumns transform of one 32-bit column
//                (a0 in the top byte).
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_single_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [3:0][7:0] w_a;
    logic [3:0][7:0] w_x2;
    logic [3:0][7:0] w_x3;

    for (genvar i = 0; i < 4; i++) begin : g_byte
        assign w_a[i]  = i_col[31-8*i -: 8];
        assign w_x2[i] = xtime(w_a[i]);
        assign w_x3[i] = w_x2[i] ^ w_a[i];
    end

    assign o_col = {w_x2[0] ^ w_x3[1] ^ w_a[2]  ^ w_a[3],
                    w_a[0]  ^ w_x2[1] ^ w_x3[2] ^ w_a[3],
                    w_a[0]  ^ w_a[1]  ^ w_x2[2] ^ w_x3[3],
                    w_x3[0] ^ w_a[1]  ^ w_a[2]  ^ w_x2[3]};

endmodule
`default_nettype wire

// File: rtl/shift_mix_columns.sv
`default_nettype none
// ============================================================================
//  Module      : shift_mix_columns
//  Description : Sequential ShiftRows + MixColumns stage, one column per clock,
//                with final-round MixColumns bypass and enable/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_mix_columns
    import aes_pkg::*;
(
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   En_SMC,
    input  logic                   Last_SMC,
    input  logic [AES_STATE_W-1:0] In_SMC,
    output logic                   Ry_SMC,
    output logic                   Busy_SMC,
    output logic [AES_STATE_W-1:0] Out_SMC
);

    logic [1:0]             r_state;
    logic [1:0]             w_state_next;
    logic [1:0]             r_col;
    logic                   r_last;
    logic [AES_STATE_W-1:0] r_work;
    logic [AES_STATE_W-1:0] w_shifted;
    logic [AES_STATE_W-1:0] w_work_next;
    logic [3:0][31:0]       w_cols;
    logic [31:0]            w_mix_in;
    logic [31:0]            w_mix_out;

    // ShiftRows is wiring; the mixed column is written back only at r_col
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign w_shifted[byte_idx(r, c) -: 8]   = In_SMC[byte_idx(r, (c + r) % 4) -: 8];
            assign w_cols[c][31-8*r -: 8]           = r_work[byte_idx(r, c) -: 8];
            assign w_work_next[byte_idx(r, c) -: 8] = (r_col == 2'(c)) ? w_mix_out[31-8*r -: 8]
                                                                       : r_work[byte_idx(r, c) -: 8];
        end
    end

    assign w_mix_in = w_cols[r_col];

    mix_single_column u_mix (
        .i_col (w_mix_in),
        .o_col (w_mix_out)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:   if (En_SMC) w_state_next = Last_SMC ? c_st_commit : c_st_mix;
            c_st_mix:    if (r_col == 2'd3 || r_last) w_state_next = c_st_commit;
            c_st_commit: w_state_next = c_st_done;
            c_st_done:   if (!En_SMC) w_state_next = c_st_idle;
            default:     w_state_next = c_st_idle;
        endcase
    end

    assign Busy_SMC = (r_state == c_st_mix) || (r_state == c_st_commit);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state <= c_st_idle;
            r_col   <= 2'd0;
            r_last  <= 1'b0;
            r_work  <= '0;
            Out_SMC <= '0;
            Ry_SMC  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_st_idle: begin
                    if (En_SMC) begin
                        r_work <= w_shifted;
                        r_last <= Last_SMC;
                        r_col  <= 2'd0;
                    end
                end
                c_st_mix: begin
                    r_work <= w_work_next;
                    r_col  <= r_col + 2'd1;
                end
                c_st_commit: begin
                    Out_SMC <= r_work;
                    Ry_SMC  <= 1'b1;
                end
                c_st_done: begin
                    if (!En_SMC) Ry_SMC <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_mix_columns.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_mix_columns
//  Description : Scoreboard bench for shift_mix_columns with a GF(2^8) model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_mix_columns;

    logic         Clk = 1'b0;
    logic         Rst;
    logic         En_SMC;
    logic         Last_SMC;
    logic [127:0] In_SMC;
    logic         Ry_SMC;
    logic         Busy_SMC;
    logic [127:0] Out_SMC;

    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] c_r1_in  = 128'hd4e0b81e27bfb44111985d52aef1e530;
    localparam logic [127:0] c_r1_out = 128'h04e0482866cbf8068119d326e59a7a4c;
    localparam logic [127:0] c_lr_out = 128'hd4e0b81ebfb441275d52119830aef1e5;
    localparam logic [127:0] c_co_in  = 128'hdbdbdbdb131313135353535345454545;
    localparam logic [127:0] c_co_out = 128'h8e8e8e8e4d4d4d4da1a1a1a1bcbcbcbc;

    shift_mix_columns dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .En_SMC   (En_SMC),
        .Last_SMC (Last_SMC),
        .In_SMC   (In_SMC),
        .Ry_SMC   (Ry_SMC),
        .Busy_SMC (Busy_SMC),
        .Out_SMC  (Out_SMC)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_smc(input logic [127:0] din, input logic last);
        logic [7:0]   s[4][4];
        logic [7:0]   t[4][4];
        logic [7:0]   m[4][4];
        logic [7:0]   acc;
        logic [127:0] res;
        m = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
              '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = din[127-8*(4*r+c) -: 8];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c+r)%4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                if (last) acc = t[r][c];
                else begin
                    acc = 8'h00;
                    for (int k = 0; k < 4; k++) acc ^= gmul(m[r][k], t[k][c]);
                end
                res[127-8*(4*r+c) -: 8] = acc;
            end
        return res;
    endfunction

    // Called at a negedge; mode 0 = hold enable, 1 = corrupt input after E1,
    // 2 = enable pulse only at E0
    task automatic run_op(input logic [127:0] din, input logic last,
                          input logic [127:0] exp, input int mode);
        int           lat;
        logic [127:0] held;
        In_SMC   = din;
        Last_SMC = last;
        En_SMC   = 1'b1;
        exp_q.push_back(exp);
        lat = 0;
        do begin
            @(posedge Clk); #1;
            lat++;
            if (mode == 2) En_SMC = 1'b0;
            if (mode == 1 && lat == 1) In_SMC = '1;
            if (!Ry_SMC) check("busy_during_op", 128'(Busy_SMC), 128'd1);
        end while (!Ry_SMC && lat < 20);
        check("latency", 128'(lat), last ? 128'd2 : 128'd6);
        if (exp_q.size() > 0) check("out_value", Out_SMC, exp_q.pop_front());
        held = Out_SMC;
        if (mode == 2) begin
            @(posedge Clk); #1;
            check("ry_single_pulse", 128'(Ry_SMC), 128'd0);
            check("out_after_pulse", Out_SMC, held);
        end else begin
            repeat (3) begin
                @(posedge Clk); #1;
                check("ry_hold_in_done", 128'(Ry_SMC), 128'd1);
                check("no_restart", 128'(Busy_SMC), 128'd0);
            end
            @(negedge Clk);
            En_SMC = 1'b0;
            @(posedge Clk); #1;
            check("ry_drop", 128'(Ry_SMC), 128'd0);
            check("out_hold", Out_SMC, held);
        end
        @(negedge Clk);
    endtask

    initial begin
        logic [127:0] rnd;
        logic         rl;
        Rst      = 1'b0;
        En_SMC   = 1'b0;
        Last_SMC = 1'b0;
        In_SMC   = '0;
        #20 Rst = 1'b1;
        @(posedge Clk); #1;
        check("reset_ry", 128'(Ry_SMC), 128'd0);
        check("reset_busy", 128'(Busy_SMC), 128'd0);
        check("reset_out", Out_SMC, 128'd0);
        @(negedge Clk);

        run_op(c_r1_in, 1'b0, c_r1_out, 0);
        run_op(c_r1_in, 1'b1, c_lr_out, 0);
        run_op(c_co_in, 1'b0, c_co_out, 0);
        run_op(c_r1_in, 1'b0, c_r1_out, 1);
        run_op(c_co_in, 1'b0, c_co_out, 2);

        for (int i = 0; i < 4; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            rl  = (i == 3);
            run_op(rnd, rl, ref_smc(rnd, rl), 0);
        end

        // Reset in the middle of a normal operation, enable still high on release
        In_SMC   = c_r1_in;
        Last_SMC = 1'b0;
        En_SMC   = 1'b1;
        repeat (4) @(posedge Clk);
        #1 Rst = 1'b0;
        #1;
        check("midrst_out", Out_SMC, 128'd0);
        check("midrst_ry", 128'(Ry_SMC), 128'd0);
        check("midrst_busy", 128'(Busy_SMC), 128'd0);
        exp_q.delete();
        @(negedge Clk);
        Rst = 1'b1;
        run_op(c_co_in, 1'b0, c_co_out, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time budget, got hang, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
